// File: rtl/cmd_sequencer_pkg.sv
// ============================================================================
// Module      : cmd_defs (package)
// Description : Shared command-format constants and sequencer state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package cmd_defs;

    localparam int CMD_WIDTH = 5;
    localparam int HALT_BIT  = 4;

    // Opcode class in command bits 4:3
    localparam logic [1:0] CMD_LOAD  = 2'b00;
    localparam logic [1:0] CMD_STORE = 2'b01;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        ISSUE = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

`default_nettype wire

// File: rtl/cmd_sequencer.sv
// ============================================================================
// Module      : cmd_sequencer
// Description : Walks a command program in async-read instruction memory and
//               hands commands one at a time to the decoder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cmd_sequencer #(
    parameter int CMD_WIDTH  = cmd_defs::CMD_WIDTH,
    parameter int ADDR_WIDTH = 6
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [ADDR_WIDTH:0]   length,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    input  logic [CMD_WIDTH-1:0]  imem_data,
    input  logic                  stall,
    output logic [CMD_WIDTH-1:0]  command,
    output logic                  cmd_valid,
    output logic                  busy,
    output logic                  done,
    output logic                  halted,
    output logic [ADDR_WIDTH:0]   issued_count
);

    import cmd_defs::*;

    state_t                r_state;
    state_t                w_state_next;
    logic [ADDR_WIDTH-1:0] r_pc;
    logic [ADDR_WIDTH-1:0] w_pc_next;
    logic [ADDR_WIDTH:0]   r_remaining;
    logic [ADDR_WIDTH:0]   w_remaining_next;
    logic [CMD_WIDTH-1:0]  r_command;
    logic [CMD_WIDTH-1:0]  w_command_next;
    logic [ADDR_WIDTH:0]   r_issued;
    logic [ADDR_WIDTH:0]   w_issued_next;
    logic                  r_halted;
    logic                  w_halted_next;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_pc        <= '0;
            r_remaining <= '0;
            r_command   <= '0;
            r_issued    <= '0;
            r_halted    <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_pc        <= w_pc_next;
            r_remaining <= w_remaining_next;
            r_command   <= w_command_next;
            r_issued    <= w_issued_next;
            r_halted    <= w_halted_next;
        end
    end

    always_comb begin
        w_state_next     = r_state;
        w_pc_next        = r_pc;
        w_remaining_next = r_remaining;
        w_command_next   = r_command;
        w_issued_next    = r_issued;
        w_halted_next    = r_halted;

        case (r_state)
            IDLE: begin
                if (start) begin
                    w_issued_next = '0;
                    w_halted_next = 1'b0;
                    if (length != '0) begin
                        w_pc_next        = base_addr;
                        w_remaining_next = length;
                        w_state_next     = FETCH;
                    end else begin
                        w_state_next = DONE;
                    end
                end
            end
            FETCH: begin
                // A halt word ends the run without ever being presented downstream
                if (imem_data[HALT_BIT]) begin
                    w_halted_next = 1'b1;
                    w_state_next  = DONE;
                end else begin
                    w_command_next   = imem_data;
                    w_pc_next        = r_pc + 1'b1;
                    w_remaining_next = r_remaining - 1'b1;
                    w_state_next     = ISSUE;
                end
            end
            ISSUE: begin
                if (!stall) begin
                    w_issued_next = r_issued + 1'b1;
                    w_state_next  = (r_remaining == '0) ? DONE : FETCH;
                end
            end
            DONE: begin
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    assign imem_addr    = r_pc;
    assign command      = r_command;
    assign cmd_valid    = (r_state == ISSUE);
    assign busy         = (r_state != IDLE);
    assign done         = (r_state == DONE);
    assign halted       = r_halted;
    assign issued_count = r_issued;

endmodule

`default_nettype wire

// File: tb/tb_cmd_sequencer.sv
// ============================================================================
// Module      : tb_cmd_sequencer
// Description : Self-checking bench for cmd_sequencer against a program-walk model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cmd_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [5:0] base_addr;
    logic [6:0] length;
    logic [5:0] imem_addr;
    logic [4:0] imem_data;
    logic       stall;
    logic [4:0] command;
    logic       cmd_valid;
    logic       busy;
    logic       done;
    logic       halted;
    logic [6:0] issued_count;

    logic [4:0] mem [64];
    assign imem_data = mem[imem_addr];

    always #5 clk = ~clk;

    cmd_sequencer #(.CMD_WIDTH(5), .ADDR_WIDTH(6)) dut (
        .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
        .length(length), .imem_addr(imem_addr), .imem_data(imem_data),
        .stall(stall), .command(command), .cmd_valid(cmd_valid), .busy(busy),
        .done(done), .halted(halted), .issued_count(issued_count)
    );

    int errors = 0;
    int checks = 0;

    logic [4:0] obs_cmds[$];
    logic [4:0] exp_cmds[$];
    logic [5:0] obs_addrs[$];
    logic [5:0] exp_addrs[$];
    bit         exp_halt;
    int         done_cnt, done_cyc, busy_cnt, stall_cyc, run_max;
    bit         saw_valid, saw_01000;
    logic [6:0] fin_issued;
    logic       fin_halted;

    // Program walk: consecutive addresses mod 64, stopping before the first halt word
    function automatic void model(input int b, input int len);
        exp_cmds.delete();
        exp_addrs.delete();
        exp_halt = 1'b0;
        for (int i = 0; i < len; i++) begin
            int a;
            a = (b + i) % 64;
            if (mem[a][4]) begin
                exp_halt = 1'b1;
                break;
            end
            exp_cmds.push_back(mem[a]);
            exp_addrs.push_back(6'(a));
        end
    endfunction

    function automatic bit same_cmds();
        if (obs_cmds.size() != exp_cmds.size()) return 1'b0;
        foreach (obs_cmds[i]) if (obs_cmds[i] !== exp_cmds[i]) return 1'b0;
        return 1'b1;
    endfunction

    function automatic bit same_addrs();
        if (obs_addrs.size() != exp_addrs.size()) return 1'b0;
        foreach (obs_addrs[i]) if (obs_addrs[i] !== exp_addrs[i]) return 1'b0;
        return 1'b1;
    endfunction

    // Busy cycles: fetch+issue per command, stall cycles, one halt fetch, one done cycle
    function automatic int exp_busy();
        return 2 * exp_cmds.size() + stall_cyc + 1 + (exp_halt ? 1 : 0);
    endfunction

    // mode: 0 no stall, 1 random stall, 2 stall 4 cycles on 2nd issue, 3 start while busy
    task automatic execute(input logic [5:0] b, input logic [6:0] len, input int mode);
        int         cyc;
        int         stall_hold;
        int         run;
        bit         prev_valid;
        logic [5:0] prev_addr;
        bit         injected;
        bit         finished;
        obs_cmds.delete();
        obs_addrs.delete();
        done_cnt = 0; done_cyc = -1; busy_cnt = 0; stall_cyc = 0; run_max = 0;
        saw_valid = 1'b0; saw_01000 = 1'b0; fin_issued = '0; fin_halted = 1'b0;
        cyc = 0; stall_hold = 0; run = 0; prev_valid = 1'b0; prev_addr = '0;
        injected = 1'b0; finished = 1'b0;
        base_addr = b; length = len; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        while (!finished && cyc < 500) begin
            if (busy) busy_cnt++;
            if (cmd_valid) saw_valid = 1'b1;
            if (cmd_valid && command == 5'b01000) saw_01000 = 1'b1;
            case (mode)
                1: stall = ($urandom_range(0, 2) == 0);
                2: begin
                    if (cmd_valid && obs_cmds.size() == 1 && stall_hold < 4) begin
                        stall = 1'b1;
                        stall_hold++;
                    end else begin
                        stall = 1'b0;
                    end
                end
                default: stall = 1'b0;
            endcase
            if (cmd_valid && !prev_valid) obs_addrs.push_back(prev_addr);
            if (cmd_valid && command == 5'b00011) begin
                run++;
                if (run > run_max) run_max = run;
            end else begin
                run = 0;
            end
            if (cmd_valid && stall) stall_cyc++;
            if (cmd_valid && !stall) obs_cmds.push_back(command);
            if (done) begin
                done_cnt++;
                done_cyc   = cyc;
                fin_issued = issued_count;
                fin_halted = halted;
                finished   = 1'b1;
            end
            if (mode == 3 && cmd_valid && !injected) begin
                start = 1'b1; base_addr = 6'd40; length = 7'd5; injected = 1'b1;
            end else begin
                start = 1'b0;
            end
            prev_valid = cmd_valid;
            prev_addr  = imem_addr;
            cyc++;
            @(negedge clk);
        end
        stall = 1'b0;
        start = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; stall = 1'b0; base_addr = '0; length = '0;
        repeat (3) @(negedge clk);
        checks++;
        if ({busy, done, cmd_valid, halted, command, issued_count, imem_addr} !== '0)
            begin errors++; $display("FAIL reset_state: busy=%b done=%b valid=%b halted=%b cmd=%b cnt=%0d addr=%0d, required all 0",
                busy, done, cmd_valid, halted, command, issued_count, imem_addr); end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        mem[0] = 5'b00000; mem[1] = 5'b00011; mem[2] = 5'b01011;
        model(0, 3);
        execute(6'd0, 7'd3, 0);
        checks++;
        if (!same_cmds()) begin errors++; $display("FAIL basic_cmds: got %0d cmds %p, required %p", obs_cmds.size(), obs_cmds, exp_cmds); end
        checks++;
        if (done_cnt !== 1 || done_cyc !== 2 * exp_cmds.size())
            begin errors++; $display("FAIL basic_done: pulses=%0d at cycle %0d, required 1 at %0d", done_cnt, done_cyc, 2 * exp_cmds.size()); end
        checks++;
        if (fin_issued !== 7'd3 || fin_halted !== 1'b0)
            begin errors++; $display("FAIL basic_status: issued=%0d halted=%b, required 3 and 0", fin_issued, fin_halted); end
        checks++;
        if (busy_cnt !== exp_busy()) begin errors++; $display("FAIL basic_busy: %0d cycles, required %0d", busy_cnt, exp_busy()); end
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL basic_idle: busy=%b done=%b, required 0 0", busy, done); end
    endtask

    task automatic test_stall();
        model(0, 3);
        execute(6'd0, 7'd3, 2);
        checks++;
        if (run_max !== 5) begin errors++; $display("FAIL stall_hold: 00011 valid for %0d cycles, required 5", run_max); end
        checks++;
        if (!same_cmds() || fin_issued !== 7'd3)
            begin errors++; $display("FAIL stall_cmds: %p issued=%0d, required %p issued=3", obs_cmds, fin_issued, exp_cmds); end
        checks++;
        if (busy_cnt !== exp_busy()) begin errors++; $display("FAIL stall_busy: %0d cycles, required %0d", busy_cnt, exp_busy()); end
    endtask

    task automatic test_halt();
        mem[0] = 5'b00111; mem[1] = 5'b10000; mem[2] = 5'b01000; mem[3] = 5'b00001;
        model(0, 4);
        execute(6'd0, 7'd4, 0);
        checks++;
        if (!same_cmds() || saw_01000) begin errors++; $display("FAIL halt_cmds: %p saw01000=%b, required %p and 0", obs_cmds, saw_01000, exp_cmds); end
        checks++;
        if (fin_halted !== 1'b1 || fin_issued !== 7'd1 || done_cnt !== 1)
            begin errors++; $display("FAIL halt_status: halted=%b issued=%0d done=%0d, required 1 1 1", fin_halted, fin_issued, done_cnt); end
        checks++;
        if (halted !== 1'b1) begin errors++; $display("FAIL halt_sticky: halted=%b in idle, required 1", halted); end
        checks++;
        if (busy_cnt !== exp_busy()) begin errors++; $display("FAIL halt_busy: %0d cycles, required %0d", busy_cnt, exp_busy()); end
    endtask

    task automatic test_wrap();
        mem[62] = 5'b00001; mem[63] = 5'b00010; mem[0] = 5'b01001;
        model(62, 3);
        execute(6'd62, 7'd3, 0);
        checks++;
        if (!same_addrs()) begin errors++; $display("FAIL wrap_addrs: %p, required %p", obs_addrs, exp_addrs); end
        checks++;
        if (!same_cmds() || fin_halted !== 1'b0)
            begin errors++; $display("FAIL wrap_cmds: %p halted=%b, required %p halted=0", obs_cmds, fin_halted, exp_cmds); end
    endtask

    task automatic test_len0();
        execute(6'd5, 7'd0, 0);
        checks++;
        if (done_cnt !== 1 || done_cyc !== 0 || saw_valid)
            begin errors++; $display("FAIL len0: done=%0d at cycle %0d valid_seen=%b, required 1 at 0 and 0", done_cnt, done_cyc, saw_valid); end
        checks++;
        if (fin_issued !== 7'd0 || busy_cnt !== 1)
            begin errors++; $display("FAIL len0_status: issued=%0d busy=%0d, required 0 and 1", fin_issued, busy_cnt); end
    endtask

    task automatic test_busy_start();
        mem[0] = 5'b00000; mem[1] = 5'b00011; mem[2] = 5'b01011;
        model(0, 3);
        execute(6'd0, 7'd3, 3);
        checks++;
        if (!same_cmds() || fin_issued !== 7'd3 || busy_cnt !== exp_busy())
            begin errors++; $display("FAIL busy_start: %p issued=%0d busy=%0d, required %p 3 %0d", obs_cmds, fin_issued, busy_cnt, exp_cmds, exp_busy()); end
        repeat (3) @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL busy_start_queue: busy=%b after run, required 0", busy); end
    endtask

    task automatic test_reset_mid();
        int n;
        mem[0] = 5'b00000; mem[1] = 5'b00011; mem[2] = 5'b01011;
        base_addr = 6'd0; length = 7'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (!cmd_valid && n < 10) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!cmd_valid) begin errors++; $display("FAIL reset_mid_wait: cmd_valid=%b, required 1 within 10 cycles", cmd_valid); end
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if ({cmd_valid, busy, done, command, issued_count} !== '0)
            begin errors++; $display("FAIL reset_mid: valid=%b busy=%b done=%b cmd=%b cnt=%0d, required all 0",
                cmd_valid, busy, done, command, issued_count); end
        reset = 1'b0;
        @(negedge clk);
        mem[10] = 5'b00101; mem[11] = 5'b01110; mem[12] = 5'b00010;
        model(10, 3);
        execute(6'd10, 7'd3, 0);
        checks++;
        if (!same_cmds() || !same_addrs() || fin_issued !== 7'd3)
            begin errors++; $display("FAIL reset_rerun: %p at %p issued=%0d, required %p at %p 3", obs_cmds, obs_addrs, fin_issued, exp_cmds, exp_addrs); end
    endtask

    task automatic test_random();
        for (int it = 0; it < 8; it++) begin
            logic [5:0] b;
            logic [6:0] len;
            for (int i = 0; i < 64; i++)
                mem[i] = {($urandom_range(0, 11) == 0), 4'($urandom)};
            b   = 6'($urandom);
            len = 7'($urandom_range(0, 64));
            model(b, len);
            execute(b, len, 1);
            checks++;
            if (!same_cmds()) begin errors++; $display("FAIL rand_cmds[%0d]: %0d cmds, required %0d", it, obs_cmds.size(), exp_cmds.size()); end
            checks++;
            if (fin_issued !== 7'(exp_cmds.size()) || fin_halted !== exp_halt)
                begin errors++; $display("FAIL rand_status[%0d]: issued=%0d halted=%b, required %0d %b", it, fin_issued, fin_halted, exp_cmds.size(), exp_halt); end
            checks++;
            if (done_cnt !== 1 || done_cyc !== exp_busy() - 1 || busy_cnt !== exp_busy())
                begin errors++; $display("FAIL rand_timing[%0d]: done=%0d at %0d busy=%0d, required 1 at %0d busy=%0d",
                    it, done_cnt, done_cyc, busy_cnt, exp_busy() - 1, exp_busy()); end
        end
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 5'b00000;
        @(negedge clk);
        test_reset();
        test_basic();
        test_stall();
        test_halt();
        test_wrap();
        test_len0();
        test_busy_start();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/cmd_sequencer.md
Name: cmd_sequencer

Overview:
- Upstream feeder for the command decoder `fsm`.
- Walks a program of 5-bit commands held in an asynchronous-read instruction memory, starting at a given base address for a given length.
- Presents one command at a time on `command`, qualified by `cmd_valid`. The downstream decoder's write enables are ANDed with `cmd_valid` at the integration level.
- Supports stall, early halt via a halt opcode, and start/busy/done handshaking with the top-level controller.

Parameters:
- CMD_WIDTH, 5, command width; must match the decoder `command` input.
- ADDR_WIDTH, 6, instruction memory address width (64 entries).

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request to run a program; sampled only in IDLE.
- base_addr  input  ADDR_WIDTH  first program address; latched on accepted start.
- length  input  ADDR_WIDTH+1  number of commands to run (0..64); latched on accepted start.
- imem_addr  output  ADDR_WIDTH  instruction memory read address (equals pc).
- imem_data  input  CMD_WIDTH  combinational memory read data for imem_addr.
- stall  input  1  downstream hold; while high, the current command is held.
- command  output  CMD_WIDTH  registered command to the decoder.
- cmd_valid  output  1  command is live this cycle.
- busy  output  1  high from accepted start until DONE exits.
- done  output  1  single-cycle completion pulse.
- halted  output  1  sticky: last run ended on a halt opcode; cleared on next accepted start.
- issued_count  output  ADDR_WIDTH+1  commands issued (stall-free handoffs) in the current or last run.

Behaviour:
- Reset (synchronous, takes priority over everything):
  - state=IDLE; pc=0; remaining=0; command=0; issued_count=0.
  - cmd_valid=0, busy=0, done=0, halted=0.
- States are IDLE, FETCH, ISSUE and DONE.
- IDLE:
  - busy=0, cmd_valid=0.
  - start=1 and length!=0: pc<=base_addr, remaining<=length, issued_count<=0, halted<=0, go to FETCH.
  - start=1 and length==0: issued_count<=0, halted<=0, go to DONE with no command issued.
- FETCH (1 cycle):
  - imem_addr=pc.
  - If imem_data[4]==1 (halt opcode): halted<=1, go to DONE. The halt opcode is never issued.
  - Otherwise: command<=imem_data, pc<=pc+1 (wraps mod 2^ADDR_WIDTH, 63->0), remaining<=remaining-1, go to ISSUE.
- ISSUE:
  - cmd_valid=1; command stays stable.
  - stall=1: remain in ISSUE; command, pc and remaining unchanged; issued_count not incremented.
  - stall=0: issued_count<=issued_count+1. If remaining==0 go to DONE, else go to FETCH.
- DONE (1 cycle): done=1, busy=1, cmd_valid=0; next state is IDLE.
- busy=1 in FETCH, ISSUE and DONE.
- start outside IDLE is ignored; there is no queuing.
- Throughput: one command per 2 cycles with no stall.
- Latency: start accepted at edge N gives the first cmd_valid in the cycle after edge N+1.
- command holds its last value outside ISSUE. Downstream must qualify it with cmd_valid, because command=0 decodes as "load A".
- Reset mid-run aborts immediately: next cycle is IDLE with all outputs at reset values; no done pulse.
- Valid commands have bit4==0: load A..H = 5'b00xxx, store J..M = 5'b010xx.
  - The sequencer does not check bits 3:0.
  - Any bit4==1 word is a halt.

Decomposition:
- Shared package `cmd_defs`:
  - CMD_WIDTH.
  - HALT_BIT index = 4.
  - Opcode constants CMD_LOAD = 2'b00 in bits 4:3 and CMD_STORE = 2'b01 in bits 4:3.
  - State encoding: IDLE=2'd0, FETCH=2'd1, ISSUE=2'd2, DONE=2'd3.
- Single module; no sub-module is needed.
- The bench carries a behavioural 64x5 asynchronous-read memory model; it is not part of the RTL.

Test Plan:
- Program at 0..2 = {5'b00000, 5'b00011, 5'b01011}; base=0, length=3; start pulse, no stall.
  - Required: cmd_valid pulses exactly 3 times, carrying 00000, 00011, 01011 in order.
  - Required: done pulses once, 1 cycle after the last issue; issued_count=3; halted=0.
- Same program with stall=1 held for 4 cycles during the second issue.
  - Required: command=5'b00011 with cmd_valid=1 for 5 consecutive cycles, then continues.
  - Required: issued_count=3 at done.
- Program at 0..3 = {5'b00111, 5'b10000, 5'b01000, 5'b00001}; base=0, length=4.
  - Required: only 00111 is issued; halted=1; issued_count=1; done pulses.
  - Required: 5'b01000 never appears with cmd_valid=1.
- Wrap-around: base=62, length=3, memory 62=5'b00001, 63=5'b00010, 0=5'b01001.
  - Required: imem_addr sequence 62, 63, 0; those three commands issued in order.
- Boundaries:
  - length=0: done pulses 1 cycle after start, cmd_valid never rises.
  - start asserted while busy: ignored; the run is unchanged.
- Reset asserted during ISSUE of a 3-command run.
  - Required: next cycle cmd_valid=0, busy=0, done=0, command=0, issued_count=0.
  - Required: a fresh start then runs normally from base_addr.
